// File: rtl/pe_dataflow_sequencer.sv
// Enable-side sequencer for one PE group tile pass: weights, partial sums, inputs, compute wait, drain.
// Optional partial-sum load phase is enabled by defining PE_SEQ_PSUM_LOAD_EN.
module pe_dataflow_sequencer #(
    parameter int W_PEGroupSize  = 4,
    parameter int O_PEGroupSize  = 4,
    parameter int I_PEGroupSize  = W_PEGroupSize + O_PEGroupSize - 1,
    parameter int W_PEAddrWidth  = 2,
    parameter int O_PEAddrWidth  = 2,
    parameter int I_PEAddrWidth  = 3,
    parameter int ComputeLatency = 3,
    parameter int LatWidth       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       W_Valid,
    input  logic       O_In_Valid,
    input  logic       I_Valid,
    input  logic       O_Out_Ready,
    output logic       EN_W,
    output logic       EN_O_In,
    output logic       EN_I,
    output logic       EN_O_Out,
    output logic       busy,
    output logic       done,
    output logic [2:0] Phase
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_W   = 3'd1,
        S_LOAD_O   = 3'd2,
        S_STREAM_I = 3'd3,
        S_WAIT     = 3'd4,
        S_DRAIN    = 3'd5
    } state_t;

    localparam logic [W_PEAddrWidth-1:0] W_LAST   = W_PEAddrWidth'(W_PEGroupSize - 1);
    localparam logic [O_PEAddrWidth-1:0] O_LAST   = O_PEAddrWidth'(O_PEGroupSize - 1);
    localparam logic [I_PEAddrWidth-1:0] I_LAST   = I_PEAddrWidth'(I_PEGroupSize - 1);
    localparam logic [LatWidth-1:0]      LAT_LOAD = LatWidth'(ComputeLatency - 1);

    state_t                   state_r;
    state_t                   state_s;
    logic [W_PEAddrWidth-1:0] w_cnt_r;
    logic [I_PEAddrWidth-1:0] i_cnt_r;
    logic [O_PEAddrWidth-1:0] o_out_cnt_r;
    logic [LatWidth-1:0]      wait_cnt_r;
    logic                     done_r;
    logic                     en_w_s;
    logic                     en_o_in_s;
    logic                     en_i_s;
    logic                     en_o_out_s;

`ifdef PE_SEQ_PSUM_LOAD_EN
    logic [O_PEAddrWidth-1:0] o_in_cnt_r;
`else
    logic                     unused_o_in_valid_s;
    assign unused_o_in_valid_s = O_In_Valid;
`endif

    // Next-state and strobe decode; strobes are gated by reset so they drop in the reset cycle
    always_comb begin
        state_s    = state_r;
        en_w_s     = 1'b0;
        en_o_in_s  = 1'b0;
        en_i_s     = 1'b0;
        en_o_out_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_LOAD_W;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD_W: begin
                en_w_s = rst & W_Valid;
                if (en_w_s && (w_cnt_r == W_LAST)) begin
`ifdef PE_SEQ_PSUM_LOAD_EN
                    state_s = S_LOAD_O;
`else
                    state_s = S_STREAM_I;
`endif
                end else begin
                    state_s = S_LOAD_W;
                end
            end
`ifdef PE_SEQ_PSUM_LOAD_EN
            S_LOAD_O: begin
                en_o_in_s = rst & O_In_Valid;
                if (en_o_in_s && (o_in_cnt_r == O_LAST)) begin
                    state_s = S_STREAM_I;
                end else begin
                    state_s = S_LOAD_O;
                end
            end
`endif
            S_STREAM_I: begin
                en_i_s = rst & I_Valid;
                if (en_i_s && (i_cnt_r == I_LAST)) begin
                    state_s = S_WAIT;
                end else begin
                    state_s = S_STREAM_I;
                end
            end
            S_WAIT: begin
                if (wait_cnt_r == {LatWidth{1'b0}}) begin
                    state_s = S_DRAIN;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_DRAIN: begin
                en_o_out_s = rst & O_Out_Ready;
                if (en_o_out_s && (o_out_cnt_r == O_LAST)) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register, mirror pointers (wrap on final transfer), wait counter and done pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            w_cnt_r     <= {W_PEAddrWidth{1'b0}};
            i_cnt_r     <= {I_PEAddrWidth{1'b0}};
            o_out_cnt_r <= {O_PEAddrWidth{1'b0}};
            wait_cnt_r  <= {LatWidth{1'b0}};
            done_r      <= 1'b0;
`ifdef PE_SEQ_PSUM_LOAD_EN
            o_in_cnt_r  <= {O_PEAddrWidth{1'b0}};
`endif
        end else begin
            state_r <= state_s;
            done_r  <= en_o_out_s && (o_out_cnt_r == O_LAST);
            if (en_w_s) begin
                w_cnt_r <= (w_cnt_r == W_LAST) ? {W_PEAddrWidth{1'b0}} : w_cnt_r + W_PEAddrWidth'(1);
            end
`ifdef PE_SEQ_PSUM_LOAD_EN
            if (en_o_in_s) begin
                o_in_cnt_r <= (o_in_cnt_r == O_LAST) ? {O_PEAddrWidth{1'b0}} : o_in_cnt_r + O_PEAddrWidth'(1);
            end
`endif
            if (en_i_s) begin
                i_cnt_r <= (i_cnt_r == I_LAST) ? {I_PEAddrWidth{1'b0}} : i_cnt_r + I_PEAddrWidth'(1);
            end
            if (en_o_out_s) begin
                o_out_cnt_r <= (o_out_cnt_r == O_LAST) ? {O_PEAddrWidth{1'b0}} : o_out_cnt_r + O_PEAddrWidth'(1);
            end
            if (en_i_s && (i_cnt_r == I_LAST)) begin
                wait_cnt_r <= LAT_LOAD;
            end else if ((state_r == S_WAIT) && (wait_cnt_r != {LatWidth{1'b0}})) begin
                wait_cnt_r <= wait_cnt_r - LatWidth'(1);
            end
        end
    end

    assign EN_W     = en_w_s;
    assign EN_O_In  = en_o_in_s;
    assign EN_I     = en_i_s;
    assign EN_O_Out = en_o_out_s;
    assign busy     = (state_r != S_IDLE);
    assign done     = done_r;
    assign Phase    = state_r;

endmodule

// File: tb/tb_pe_dataflow_sequencer.sv
// Bench for pe_dataflow_sequencer: directed pass scenarios plus randomized traffic against a queue-of-steps model.
module tb_pe_dataflow_sequencer;

    localparam int W   = 4;
    localparam int O   = 4;
    localparam int I   = 7;
    localparam int LAT = 3;
`ifdef PE_SEQ_PSUM_LOAD_EN
    localparam int OIN = O;
`else
    localparam int OIN = 0;
`endif
    localparam int DONE_CYC = W + OIN + I + LAT + O + 1;

    // Step kinds carry the phase encoding of the state they occur in.
    localparam int K_W  = 1;
    localparam int K_O  = 2;
    localparam int K_I  = 3;
    localparam int K_WT = 4;
    localparam int K_D  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       W_Valid = 1'b0, O_In_Valid = 1'b0, I_Valid = 1'b0, O_Out_Ready = 1'b0;
    logic       EN_W, EN_O_In, EN_I, EN_O_Out, busy, done;
    logic [2:0] Phase;

    int   checks = 0;
    int   failures = 0;
    int   q[$];
    logic done_exp = 1'b0;
    logic done_obs;
    int   en_w_cnt, en_out_cnt, done_cnt;

    pe_dataflow_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .W_Valid(W_Valid), .O_In_Valid(O_In_Valid), .I_Valid(I_Valid), .O_Out_Ready(O_Out_Ready),
        .EN_W(EN_W), .EN_O_In(EN_O_In), .EN_I(EN_I), .EN_O_Out(EN_O_Out),
        .busy(busy), .done(done), .Phase(Phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic fill_pass();
        repeat (W) q.push_back(K_W);
        repeat (OIN) q.push_back(K_O);
        repeat (I) q.push_back(K_I);
        repeat (LAT) q.push_back(K_WT);
        repeat (O) q.push_back(K_D);
    endtask

    task automatic cyc(input logic r, input logic s, input logic wv, input logic ov,
                       input logic iv, input logic rdy);
        logic idle;
        int   k;
        @(negedge clk);
        rst = r; start = s; W_Valid = wv; O_In_Valid = ov; I_Valid = iv; O_Out_Ready = rdy;
        #1;
        idle = (q.size() == 0);
        k = idle ? 0 : q[0];
        chk("en_w", EN_W, r && k == K_W && wv);
        chk("en_o_in", EN_O_In, r && k == K_O && ov);
        chk("en_i", EN_I, r && k == K_I && iv);
        chk("en_o_out", EN_O_Out, r && k == K_D && rdy);
        chk("busy", busy, !idle);
        chk("done", done, done_exp);
        chk("phase", Phase, k);
        done_obs = done;
        en_w_cnt += EN_W;
        en_out_cnt += EN_O_Out;
        done_cnt += done;
        @(posedge clk);
        done_exp = 1'b0;
        if (!r) begin
            q.delete();
        end else if (idle) begin
            if (s) fill_pass();
        end else begin
            case (k)
                K_W:  if (wv) void'(q.pop_front());
                K_O:  if (ov) void'(q.pop_front());
                K_I:  if (iv) void'(q.pop_front());
                K_WT: void'(q.pop_front());
                K_D:  if (rdy) begin
                          void'(q.pop_front());
                          if (q.size() == 0) done_exp = 1'b1;
                      end
                default: ;
            endcase
        end
    endtask

    task automatic run_full(input int ncyc);
        int done_at = -1;
        for (int c = 0; c < ncyc; c++) begin
            cyc(1'b1, c == 0, 1'b1, 1'b1, 1'b1, 1'b1);
            if (done_obs) done_at = c;
        end
        chk("done_cycle", 8'(done_at), 8'(DONE_CYC));
    endtask

    initial begin
        en_w_cnt = 0; en_out_cnt = 0; done_cnt = 0;
        repeat (2) @(posedge clk);
        repeat (2) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        run_full(DONE_CYC + 3);

        en_w_cnt = 0;
        for (int c = 0; c < DONE_CYC + 6; c++)
            cyc(1'b1, c == 0, !(c >= 2 && c <= 4), 1'b1, 1'b1, 1'b1);
        chk("w_pulses", 8'(en_w_cnt), 8'(W));

        en_out_cnt = 0; done_cnt = 0;
        for (int c = 0; c < DONE_CYC + 8; c++)
            cyc(1'b1, c == 0, 1'b1, 1'b1, 1'b1, c[0]);
        chk("drain_pulses", 8'(en_out_cnt), 8'(O));
        chk("drain_done_cnt", 8'(done_cnt), 8'd1);

        for (int c = 0; c < W + OIN + 4; c++)
            cyc(1'b1, c == 0, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        run_full(DONE_CYC + 3);

        done_cnt = 0;
        for (int c = 0; c < DONE_CYC + 6; c++)
            cyc(1'b1, c == 0 || c == W + OIN + I + 2, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("wait_start_done_cnt", 8'(done_cnt), 8'd1);

        for (int c = 0; c < 3000; c++)
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_dataflow_sequencer.md
# pe_dataflow_sequencer

Drives the enable side of the PE group address controller. It issues the `EN_W`, `EN_I`, `EN_O_In` and `EN_O_Out` strobes for one tile pass in a fixed order: weights, partial sums in, inputs, compute wait, then output drain. Each strobe is qualified by a valid/ready handshake with the edge buffers. The block mirrors the controller's address pointers, so both sides wrap to 0 together at the end of every pass.

## Interface
Parameters:
- `W_PEGroupSize`, 4: weights per pass
- `O_PEGroupSize`, 4: outputs per pass
- `I_PEGroupSize`, `W_PEGroupSize + O_PEGroupSize - 1`: inputs per pass
- `W_PEAddrWidth` / `O_PEAddrWidth` / `I_PEAddrWidth`, 2 / 2 / 3: mirror counter widths
- `ComputeLatency`, 3: idle cycles between last input and first drain (≥1)
- `LatWidth`, 4: wait counter width

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-low reset
- `start` in 1: begin a pass; sampled only in IDLE
- `W_Valid` / `O_In_Valid` / `I_Valid` in 1 each: source buffer has a word
- `O_Out_Ready` in 1: output sink accepts a word
- `EN_W` / `EN_O_In` / `EN_I` / `EN_O_Out` out 1 each: transfer strobe to the PE controller and buffer (acts as ready/pop)
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle pulse after the last drain transfer
- `Phase` out 3: state encoding, for debug

## Operation
- States and encoding: IDLE=0, LOAD_W=1, LOAD_O=2, STREAM_I=3, WAIT=4, DRAIN=5.
- IDLE: when `start`=1, go to LOAD_W.
- LOAD_W:
  - `EN_W = W_Valid`.
  - Count transfers; on the transfer with count = `W_PEGroupSize-1`, clear the count and go to LOAD_O.
- LOAD_O: `EN_O_In = O_In_Valid`; after `O_PEGroupSize` transfers, go to STREAM_I.
- STREAM_I: `EN_I = I_Valid`; after `I_PEGroupSize` transfers, load the wait counter and go to WAIT.
- WAIT: no strobes. Count down `ComputeLatency` cycles, then go to DRAIN.
- DRAIN: `EN_O_Out = O_Out_Ready`; after `O_PEGroupSize` transfers, go to IDLE and register `done`=1 for one cycle.
- Strobes:
  - All EN outputs are combinational from the state register and the matching valid/ready.
  - At most one EN is high in any cycle.
  - All EN outputs are 0 in IDLE and WAIT.
- A transfer is a cycle with EN=1. Valid low stalls the state indefinitely with no timeout; the count is held.
- Mirror counters wrap to 0 on their final transfer, identical to the controller pointers. At every IDLE entry all pointers on both sides are 0.
- `start` while busy is ignored; `start` held high in IDLE restarts immediately after `done`.

## Timing
- Reset (`rst`=0 at a clock edge):
  - state becomes IDLE; all counters become 0.
  - `done`=0 and `busy`=0.
  - All EN outputs are 0 in the same cycle because they are gated by `rst`.
- Reset mid-pass aborts without `done`. The controller is reset by the same `rst`, so its pointers stay aligned.
- `start` sampled at edge N puts LOAD_W in effect from cycle N+1. The first `EN_W` can appear in cycle N+1.
- Each phase takes its group size in transfer cycles when valid is held high; there are no bubble cycles between phases.
- `done` is high in the first IDLE cycle; `busy` is 0 in that cycle.
- Minimum pass with valid/ready held high and the macro on: `W+O+I+ComputeLatency+O` cycles from the first LOAD_W cycle to the last drain cycle. This is 4+4+7+3+4 = 22 with the defaults.

## Configuration
- `PE_SEQ_PSUM_LOAD_EN` defined: LOAD_O is present, as described above.
- `PE_SEQ_PSUM_LOAD_EN` undefined:
  - LOAD_W goes directly to STREAM_I.
  - `EN_O_In` is tied to 0 and `O_In_Valid` is ignored.
  - The PEs start from zero; the minimum pass with defaults is 18 cycles.
- Encoding value 2 is unused when the macro is undefined.

## Test plan
- Reset, then all valid/ready=1, `start` pulse at cycle 0:
  - `EN_W` high in cycles 1–4, `EN_O_In` in 5–8, `EN_I` in 9–15.
  - No EN in 16–18; `EN_O_Out` in 19–22.
  - `done` high in cycle 23 only.
- `W_Valid` low for cycles 2–4 during LOAD_W: exactly 4 `EN_W` pulses in total, and LOAD_O starts one cycle after the 4th.
- `O_Out_Ready` toggling 1/0 in DRAIN: `EN_O_Out` follows ready, 4 pulses in total, and `done` follows the 4th pulse by one cycle.
- `rst`=0 during STREAM_I after 3 inputs:
  - Next cycle is IDLE, with no `done` and all EN=0.
  - A new `start` reproduces the first scenario's timing.
- `start` pulsed during WAIT: ignored, so exactly one `done`.
- Macro undefined: `EN_I` high in cycles 5–11 directly after LOAD_W, `EN_O_In` is never high, and `done` is high in cycle 19.
